// File: rtl/man_dec_pkg.sv
// Shared types and window-bound helpers for the Manchester decoder.
package man_dec_pkg;

  typedef enum logic [1:0] {HUNT, LOCKING, LOCKED} man_dec_state_t;

  function automatic int unsigned man_dec_timer_w(input int unsigned os);
    return $clog2(2 * os + 2);
  endfunction

  function automatic int unsigned man_dec_mid_lo(input int unsigned os, input int unsigned tol);
    return os - tol;
  endfunction

  function automatic int unsigned man_dec_mid_hi(input int unsigned os, input int unsigned tol);
    return os + tol;
  endfunction

  function automatic int unsigned man_dec_half_lo(input int unsigned os, input int unsigned tol);
    return os / 2 - tol;
  endfunction

  function automatic int unsigned man_dec_half_hi(input int unsigned os, input int unsigned tol);
    return os / 2 + tol;
  endfunction

endpackage

// File: rtl/man_dec_edge_sync.sv
// Line synchronizer, optional 3-sample majority filter, registered edge/direction.
// Filter enabled by defining MAN_DEC_GLITCH_FILTER_EN.
module man_dec_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_edge,
  output logic o_dir
);

  logic r_s1;
  logic r_s2;
  logic r_lvl_d;
  logic r_edge;
  logic r_dir;
  logic w_level;

`ifdef MAN_DEC_GLITCH_FILTER_EN
  logic r_h1;
  logic r_h2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h1 <= 1'b0;
      r_h2 <= 1'b0;
    end else begin
      r_h1 <= r_s2;
      r_h2 <= r_h1;
    end
  end

  // Combinational vote keeps the added delay to one clock for every edge.
  assign w_level = (r_s2 & r_h1) | (r_s2 & r_h2) | (r_h1 & r_h2);
`else
  assign w_level = r_s2;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_lvl_d <= 1'b0;
      r_edge  <= 1'b0;
      r_dir   <= 1'b0;
    end else begin
      r_s1    <= i_line;
      r_s2    <= r_s1;
      r_lvl_d <= w_level;
      r_edge  <= w_level ^ r_lvl_d;
      r_dir   <= w_level;
    end
  end

  assign o_edge = r_edge;
  assign o_dir  = r_dir;

endmodule

// File: rtl/man_decoder.sv
// IEEE 802.3 Manchester receive decoder: lock acquisition, NRZ recovery, violation flag.
// Optional glitch filter via MAN_DEC_GLITCH_FILTER_EN (see man_dec_edge_sync).
module man_decoder
  import man_dec_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned TOL        = 3,
  parameter int unsigned LOCK_BITS  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic bit_out,
  output logic bit_valid,
  output logic locked,
  output logic code_err
);

  localparam int unsigned TW = man_dec_timer_w(OVERSAMPLE);
  localparam int unsigned GW = $clog2(LOCK_BITS + 1);

  localparam logic [TW-1:0] T_MAX   = TW'(2 * OVERSAMPLE + 1);
  localparam logic [TW-1:0] T_OUT   = TW'(OVERSAMPLE + TOL + 1);
  localparam logic [TW-1:0] MID_LO  = TW'(man_dec_mid_lo(OVERSAMPLE, TOL));
  localparam logic [TW-1:0] MID_HI  = TW'(man_dec_mid_hi(OVERSAMPLE, TOL));
  localparam logic [TW-1:0] HALF_LO = TW'(man_dec_half_lo(OVERSAMPLE, TOL));
  localparam logic [TW-1:0] HALF_HI = TW'(man_dec_half_hi(OVERSAMPLE, TOL));
  localparam logic [GW-1:0] G_LOCK  = GW'(LOCK_BITS);

  logic w_edge;
  logic w_dir;

  man_dec_edge_sync u_edge_sync (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_line  (line_in),
    .o_edge  (w_edge),
    .o_dir   (w_dir)
  );

  man_dec_state_t r_state, w_state_nx;
  logic [TW-1:0]  r_timer, w_timer_nx, w_t;
  logic [GW-1:0]  r_good, w_good_nx, w_good_inc;
  logic           r_anchor, w_anchor_nx;
  logic           r_bit, w_bit_nx;
  logic           r_valid, w_valid_nx;
  logic           r_err, w_err_nx;
  logic           r_locked;
  logic           w_mid, w_half, w_late;

  // w_t is the spacing in clocks from the last accepted mid-bit edge to this clock.
  assign w_t        = (r_timer == T_MAX) ? T_MAX : r_timer + TW'(1);
  assign w_mid      = (w_t >= MID_LO) && (w_t <= MID_HI);
  assign w_half     = (w_t >= HALF_LO) && (w_t <= HALF_HI);
  assign w_late     = (w_t >= T_OUT);
  assign w_good_inc = r_good + GW'(1);

  always_comb begin
    w_state_nx  = r_state;
    w_timer_nx  = w_t;
    w_good_nx   = r_good;
    w_anchor_nx = r_anchor;
    w_bit_nx    = r_bit;
    w_valid_nx  = 1'b0;
    w_err_nx    = 1'b0;
    unique case (r_state)
      HUNT: begin
        if (w_edge) begin
          w_timer_nx  = '0;
          w_anchor_nx = 1'b1;
          if (r_anchor && w_mid) begin
            w_state_nx = LOCKING;
            w_good_nx  = GW'(1);
          end
        end
      end
      LOCKING: begin
        if (w_edge && w_mid) begin
          w_timer_nx = '0;
          w_good_nx  = w_good_inc;
          if (w_good_inc == G_LOCK) w_state_nx = LOCKED;
        end else if ((w_edge && !w_half) || (!w_edge && w_late)) begin
          w_err_nx    = 1'b1;
          w_state_nx  = HUNT;
          w_good_nx   = '0;
          w_anchor_nx = 1'b0;
          w_timer_nx  = '0;
        end
      end
      LOCKED: begin
        if (w_edge && w_mid) begin
          w_timer_nx = '0;
          w_valid_nx = 1'b1;
          w_bit_nx   = w_dir;
        end else if ((w_edge && !w_half) || (!w_edge && w_late)) begin
          w_err_nx    = 1'b1;
          w_state_nx  = HUNT;
          w_good_nx   = '0;
          w_anchor_nx = 1'b0;
          w_timer_nx  = '0;
        end
      end
      default: begin
        w_state_nx  = HUNT;
        w_good_nx   = '0;
        w_anchor_nx = 1'b0;
        w_timer_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= HUNT;
      r_timer  <= '0;
      r_good   <= '0;
      r_anchor <= 1'b0;
      r_bit    <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_timer  <= w_timer_nx;
      r_good   <= w_good_nx;
      r_anchor <= w_anchor_nx;
      r_bit    <= w_bit_nx;
      r_valid  <= w_valid_nx;
      r_err    <= w_err_nx;
      r_locked <= (w_state_nx == LOCKED);
    end
  end

  assign bit_out   = r_bit;
  assign bit_valid = r_valid;
  assign locked    = r_locked;
  assign code_err  = r_err;

endmodule

// File: tb/tb_man_decoder.sv
// Directed, table-driven bench for man_decoder (defaults 16/3/8).
module tb_man_decoder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic line_in = 1'b0;
  logic bit_out, bit_valid, locked, code_err;

  man_decoder #(.OVERSAMPLE(16), .TOL(3), .LOCK_BITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .line_in   (line_in),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .locked    (locked),
    .code_err  (code_err)
  );

  always #5 clk = ~clk;

`ifdef MAN_DEC_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_strobe = 0;
  int n_err = 0;
  int cyc_valid = 0;
  int cyc_err = 0;
  logic last_bit = 1'b0;
  logic prev_err = 1'b0;
  logic lock_after_err = 1'b1;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (bit_valid) begin
      n_strobe = n_strobe + 1;
      last_bit = bit_out;
      cyc_valid = cyc;
    end
    if (prev_err) lock_after_err = locked;
    if (code_err) begin
      n_err = n_err + 1;
      cyc_err = cyc;
    end
    prev_err = code_err;
  end

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // IEEE 802.3: '1' is low->high at mid-bit, '0' is high->low.
  task automatic send_bit(input logic b);
    line_in = ~b;
    clk_wait(8);
    line_in = b;
    clk_wait(8);
  endtask

  typedef struct {
    logic b;
    int   exp_strobes;
    logic exp_bit;
    logic exp_lock;
  } vec_t;

  vec_t acq[18];
  logic [7:0] payload;
  int s0, e0, t_tog;

  initial begin
    payload = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      acq[i].b           = (i % 2 == 0) ? 1'b1 : 1'b0;
      acq[i].exp_strobes = (i == 9) ? 1 : 0;
      acq[i].exp_bit     = 1'b0;
      acq[i].exp_lock    = (i >= 8);
    end
    for (int j = 0; j < 8; j++) begin
      acq[10+j].b           = payload[7-j];
      acq[10+j].exp_strobes = 1;
      acq[10+j].exp_bit     = payload[7-j];
      acq[10+j].exp_lock    = 1'b1;
    end

    // Reset held while the line toggles.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 line_in = ~line_in;
      @(negedge clk);
      check("reset_outputs", int'({bit_out, bit_valid, locked, code_err}), 0);
    end
    @(posedge clk);
    #1;
    line_in = 1'b0;
    reset = 1'b1;
    clk_wait(20);
    check("post_reset_locked", int'(locked), 0);
    check("post_reset_strobes", n_strobe, 0);
    check("post_reset_err", n_err, 0);

    // Acquisition: preamble 1010101010 then 0xA5.
    for (int i = 0; i < 18; i++) begin
      s0 = n_strobe;
      e0 = n_err;
      send_bit(acq[i].b);
      check($sformatf("acq%0d_strobes", i), n_strobe - s0, acq[i].exp_strobes);
      if (acq[i].exp_strobes > 0)
        check($sformatf("acq%0d_bit", i), int'(last_bit), int'(acq[i].exp_bit));
      check($sformatf("acq%0d_locked", i), int'(locked), int'(acq[i].exp_lock));
      check($sformatf("acq%0d_err", i), n_err - e0, 0);
    end

    // Jitter: spacings 13 and 19 accepted, 12 rejected. Line is high, 8 clk past mid.
    s0 = n_strobe; e0 = n_err;
    clk_wait(5);
    line_in = 1'b0;
    t_tog = cyc;
    clk_wait(8);
    check("jit13_strobe", n_strobe - s0, 1);
    check("jit13_bit", int'(last_bit), 0);
    check("jit13_latency", cyc_valid - t_tog, LAT);
    check("jit13_err", n_err - e0, 0);
    s0 = n_strobe;
    clk_wait(11);
    line_in = 1'b1;
    clk_wait(8);
    check("jit19_strobe", n_strobe - s0, 1);
    check("jit19_bit", int'(last_bit), 1);
    check("jit19_err", n_err - e0, 0);
    check("jit19_locked", int'(locked), 1);
    clk_wait(4);
    line_in = 1'b0;
    clk_wait(8);
    check("jit12_err_pulse", n_err - e0, 1);
    check("jit12_lock_after_err", int'(lock_after_err), 0);
    check("jit12_locked", int'(locked), 0);

    // Constant '1' data: edges every 8 clk, must never lock or flag.
    s0 = n_strobe; e0 = n_err;
    for (int i = 0; i < 20; i++) begin
      send_bit(1'b1);
      check($sformatf("ones%0d_locked", i), int'(locked), 0);
    end
    check("ones_err", n_err - e0, 0);
    check("ones_strobes", n_strobe - s0, 0);

    s0 = n_strobe;
    for (int i = 0; i < 10; i++) send_bit((i % 2 == 0) ? 1'b1 : 1'b0);
    check("relock_locked", int'(locked), 1);
    check("relock_strobes", n_strobe - s0, 1);
    check("relock_bit", int'(last_bit), 0);
    check("relock_err", n_err - e0, 0);

    // Missing transition: line held 25 clk after the last mid-bit edge.
    clk_wait(17);
    check("miss_err_pulse", n_err - e0, 1);
    check("miss_err_delay", cyc_err - cyc_valid, 20);
    check("miss_locked", int'(locked), 0);

    // Re-acquire, then a 1-clk glitch inside the first half of a '1' bit.
    e0 = n_err;
    for (int i = 0; i < 10; i++) send_bit((i % 2 == 0) ? 1'b1 : 1'b0);
    check("glitch_pre_locked", int'(locked), 1);
    s0 = n_strobe;
    line_in = 1'b0;
    clk_wait(3);
    line_in = 1'b1;
    clk_wait(1);
    line_in = 1'b0;
    clk_wait(4);
    line_in = 1'b1;
    clk_wait(8);
`ifdef MAN_DEC_GLITCH_FILTER_EN
    check("glitch_err", n_err - e0, 0);
    check("glitch_strobe", n_strobe - s0, 1);
    check("glitch_bit", int'(last_bit), 1);
    check("glitch_locked", int'(locked), 1);
`else
    check("glitch_err", n_err - e0, 1);
    check("glitch_strobe", n_strobe - s0, 0);
    check("glitch_locked", int'(locked), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/man_decoder.md
Name: man_decoder

Overview:
Receive-side Manchester decoder (IEEE 802.3 convention) for the coder chain: consumes the serial line produced by the IEEE encoder and recovers NRZ bits plus a strobe.
Runs on the fast system clock, undivided, oversampling the line at OVERSAMPLE clocks per bit; OVERSAMPLE matches the divide-by-16 bit clock of the transmit side.
Tracks mid-bit transitions, acquires and holds lock, and flags coding violations.

Parameters:
OVERSAMPLE, 16, system clocks per Manchester bit (even, >= 8)
TOL, 3, +/- clock tolerance on every edge-spacing window (< OVERSAMPLE/4)
LOCK_BITS, 8, consecutive valid mid-bit edges needed to declare lock

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
line_in  in  1  Manchester line, asynchronous to clk
bit_out  out  1  decoded bit; valid only when bit_valid=1
bit_valid  out  1  one-clk strobe per decoded bit
locked  out  1  high while state=LOCKED
code_err  out  1  one-clk pulse on coding/timing violation

Behaviour:
- Reset (reset=0, async): sync flops=0, timer=0, good_cnt=0, state=HUNT; bit_out=0, bit_valid=0, locked=0, code_err=0.
- Input path: 2-flop synchronizer, then an edge register. edge = sync ^ sync_d; dir = sync (new level).
- timer: counts clocks since the last accepted mid-bit edge. Width $clog2(2*OVERSAMPLE+2). Saturates at 2*OVERSAMPLE+1. Reloads 0 on an accepted mid-bit edge.
- Windows, with T = timer at the edge:
  - MID: OVERSAMPLE-TOL <= T <= OVERSAMPLE+TOL.
  - HALF: OVERSAMPLE/2-TOL <= T <= OVERSAMPLE/2+TOL.
  - Any other T is BAD.
- State HUNT:
  - First edge after entry: timer=0, stay in HUNT.
  - Next edge in MID: go to LOCKING, good_cnt=1, timer=0.
  - Next edge in HALF or BAD: timer=0, stay in HUNT (candidate re-anchored). No code_err in HUNT.
- State LOCKING:
  - Edge in HALF: bit-boundary edge, ignored, timer keeps running.
  - Edge in MID: good_cnt++, timer=0. When good_cnt reaches LOCK_BITS, go to LOCKED on that edge.
  - Edge in BAD, or timer > OVERSAMPLE+TOL: code_err pulse, go to HUNT.
- State LOCKED:
  - Edge in MID: bit_valid=1 for one clk, bit_out = dir (0->1 = '1', 1->0 = '0'), timer=0.
  - Edge in HALF: ignored.
  - BAD edge, or timer reaching OVERSAMPLE+TOL+1 with no edge: code_err for one clk, locked=0 next clk, go to HUNT, good_cnt=0.
- The edge that completes lock produces no bit. The first bit_valid comes on the following mid-bit edge.
- Latency: line_in change to bit_valid = 4 clk (2 sync + edge reg + output reg).
- Outputs are registered. bit_out holds its value between strobes.
- Simultaneous edge and timeout threshold: the edge wins, i.e. it is evaluated against the windows.
- reset asserted mid-frame: immediate async clear. Lock must be fully re-acquired after release.

Optional Feature:
- Macro MAN_DEC_GLITCH_FILTER_EN.
- Defined: a 3-sample majority filter sits after the synchronizer. Single-clk line pulses are removed. Latency becomes 5 clk; window checks are unchanged because the filter delays all edges equally.
- Undefined: no filter, latency 4 clk, and a 1-clk glitch is treated as a real edge (normally giving code_err).

Decomposition:
- Package man_dec_pkg holds:
  - typedef enum logic [1:0] {HUNT, LOCKING, LOCKED} man_dec_state_t
  - localparam functions for the MID/HALF window bounds
  - the timer width constant
- One sub-module, man_dec_edge_sync: synchronizer, optional majority filter, and edge/dir detection.
- The FSM, timer and output registers stay in man_decoder.

Test Plan:
- Reset: hold reset=0 for 5 clk while line_in toggles -> all outputs 0, no bit_valid or code_err; after release, locked=0 until a preamble is received.
- Acquire + data (defaults): 10 alternating preamble bits 1010101010, then payload 0xA5 MSB-first at 16 clk/bit -> locked rises on the 8th mid-bit edge; the following strobes give 1,0,1,0,0,1,0,1 (after the remaining preamble bits); exactly one bit_valid per bit.
- Jitter: in LOCKED, mid-bit edge spacings of 13 and 19 clk -> accepted, no code_err; a spacing of 12 clk -> code_err pulse, locked=0 one clk later, state HUNT.
- Missing transition: in LOCKED, hold line_in constant for 25 clk -> code_err exactly 20 clk after the last mid-bit edge (plus pipeline), then HUNT.
- Constant-data acquisition: 20 bits of all '1' (edge spacing always 8) -> stays HUNT, never locks, no code_err; then alternating bits -> locks normally.
- Glitch with MAN_DEC_GLITCH_FILTER_EN defined: 1-clk pulse mid-bit in LOCKED -> no code_err, bit stream intact, latency 5 clk. Without the macro, the same pulse -> code_err.
